// File: rtl/rs_pkg.sv
// Shared widths, the reservation-station entry layout and the ROB age helper
// for the second-generation ALU reservation station.
package rs_pkg;

  localparam int ROB_POS_W = 4;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int OPCODE_W  = 7;
  localparam int FUNCT3_W  = 3;

  typedef logic [ROB_POS_W-1:0] rob_pos_t;

  typedef struct packed {
    logic                busy;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic                funct7;
    logic                pend1;
    rob_pos_t            tag1;
    logic [DATA_W-1:0]   val1;
    logic                pend2;
    rob_pos_t            tag2;
    logic [DATA_W-1:0]   val2;
    logic [DATA_W-1:0]   imm;
    logic [ADDR_W-1:0]   pc;
    rob_pos_t            rob_pos;
  } rs_entry_t;

  // Distance from the ROB head; smaller means older. Wraps with the ROB index.
  function automatic rob_pos_t rob_age(input rob_pos_t pos, input rob_pos_t head);
    return rob_pos_t'(pos - head);
  endfunction

endpackage

// File: rtl/rs_gen2_if.sv
// Issue / broadcast / dispatch bundle between the issue stage, the CDBs, the
// ALU and the reservation station. The RS side uses the slave modport.
interface rs_gen2_if #(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 2
);
  import rs_pkg::*;

  logic                           rdy;
  logic                           rollback;
  rob_pos_t                       rob_head;

  logic                           issue;
  rob_pos_t                       issue_rob_pos;
  logic [OPCODE_W-1:0]            issue_opcode;
  logic [FUNCT3_W-1:0]            issue_funct3;
  logic                           issue_funct7;
  logic                           issue_rs1_pend;
  logic                           issue_rs2_pend;
  rob_pos_t                       issue_rs1_tag;
  rob_pos_t                       issue_rs2_tag;
  logic [DATA_W-1:0]              issue_rs1_val;
  logic [DATA_W-1:0]              issue_rs2_val;
  logic [DATA_W-1:0]              issue_imm;
  logic [ADDR_W-1:0]              issue_pc;

  logic                           rs_full;
  logic [$clog2(DEPTH):0]         free_count;

  logic [NUM_CDB-1:0]             cdb_valid;
  logic [NUM_CDB*ROB_POS_W-1:0]   cdb_rob_pos;
  logic [NUM_CDB*DATA_W-1:0]      cdb_val;

  logic                           alu_en;
  logic [OPCODE_W-1:0]            alu_opcode;
  logic [FUNCT3_W-1:0]            alu_funct3;
  logic                           alu_funct7;
  logic [DATA_W-1:0]              alu_val1;
  logic [DATA_W-1:0]              alu_val2;
  logic [DATA_W-1:0]              alu_imm;
  logic [ADDR_W-1:0]              alu_pc;
  rob_pos_t                       alu_rob_pos;

  modport slave (
    input  rdy, rollback, rob_head,
    input  issue, issue_rob_pos, issue_opcode, issue_funct3, issue_funct7,
    input  issue_rs1_pend, issue_rs2_pend, issue_rs1_tag, issue_rs2_tag,
    input  issue_rs1_val, issue_rs2_val, issue_imm, issue_pc,
    input  cdb_valid, cdb_rob_pos, cdb_val,
    output rs_full, free_count,
    output alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
    output alu_imm, alu_pc, alu_rob_pos
  );

  modport master (
    output rdy, rollback, rob_head,
    output issue, issue_rob_pos, issue_opcode, issue_funct3, issue_funct7,
    output issue_rs1_pend, issue_rs2_pend, issue_rs1_tag, issue_rs2_tag,
    output issue_rs1_val, issue_rs2_val, issue_imm, issue_pc,
    output cdb_valid, cdb_rob_pos, cdb_val,
    input  rs_full, free_count,
    input  alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
    input  alu_imm, alu_pc, alu_rob_pos
  );

endinterface

// File: rtl/rs_age_select.sv
// Combinational oldest-ready picker: among ready entries, the one whose ROB
// position is closest to the head wins; ties fall to the lower index.
module rs_age_select
  import rs_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]         ready_i,
  input  rob_pos_t                 rob_pos_i [DEPTH],
  input  rob_pos_t                 rob_head_i,
  output logic                     sel_valid_o,
  output logic [$clog2(DEPTH)-1:0] sel_idx_o
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             found;
  logic [IDX_W-1:0] best_idx;
  rob_pos_t         best_age;
  rob_pos_t         age;

  // Linear scan; strict less-than keeps the lower index on equal ages.
  always_comb begin
    found    = 1'b0;
    best_idx = '0;
    best_age = '0;
    age      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = rob_age(rob_pos_i[i], rob_head_i);
      if (ready_i[i] && (!found || age < best_age)) begin
        found    = 1'b1;
        best_idx = IDX_W'(i);
        best_age = age;
      end
    end
    sel_valid_o = found;
    sel_idx_o   = best_idx;
  end

endmodule

// File: rtl/rs_gen2.sv
// Second-generation ALU reservation station: buffers issued instructions,
// captures operands from the result broadcasts (including on the issue
// cycle), and dispatches the oldest ready entry to the ALU each cycle.
module rs_gen2
  import rs_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  rs_gen2_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t           entry_q [DEPTH];
  rs_entry_t           entry_d [DEPTH];
  rs_entry_t           new_entry;
  logic [CNT_W-1:0]    free_count_q, free_count_d;

  logic                alu_en_q;
  logic [OPCODE_W-1:0] alu_opcode_q;
  logic [FUNCT3_W-1:0] alu_funct3_q;
  logic                alu_funct7_q;
  logic [DATA_W-1:0]   alu_val1_q, alu_val2_q, alu_imm_q;
  logic [ADDR_W-1:0]   alu_pc_q;
  rob_pos_t            alu_rob_pos_q;

  logic [DEPTH-1:0]    ready;
  rob_pos_t            pos_arr [DEPTH];
  logic                sel_valid;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    free_idx;
  logic                issue_accept;
  logic [DATA_W:0]     byp1, byp2, wk1, wk2;
  logic                cdb_dup;

  // Returns {hit, value}; scanning downward lets the lowest matching channel win.
  function automatic logic [DATA_W:0] cdb_lookup(
    input rob_pos_t                     tag,
    input logic [NUM_CDB-1:0]           valid,
    input logic [NUM_CDB*ROB_POS_W-1:0] tags,
    input logic [NUM_CDB*DATA_W-1:0]    vals
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (valid[k] && tags[k*ROB_POS_W +: ROB_POS_W] == tag)
        res = {1'b1, vals[k*DATA_W +: DATA_W]};
    end
    return res;
  endfunction

  // Ready vector and ROB positions for the age picker, from registered state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i]   = entry_q[i].busy && !entry_q[i].pend1 && !entry_q[i].pend2;
      pos_arr[i] = entry_q[i].rob_pos;
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_sel (
    .ready_i     (ready),
    .rob_pos_i   (pos_arr),
    .rob_head_i  (bus.rob_head),
    .sel_valid_o (sel_valid),
    .sel_idx_o   (sel_idx)
  );

  // Lowest free index from pre-edge state, so a slot freed by dispatch is not reused this cycle.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entry_q[i].busy) free_idx = IDX_W'(i);
    end
  end

  assign issue_accept = bus.issue && (free_count_q != '0);

  // Build the incoming entry, taking any operand broadcast in the same cycle.
  always_comb begin
    byp1 = cdb_lookup(bus.issue_rs1_tag, bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val);
    byp2 = cdb_lookup(bus.issue_rs2_tag, bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val);
    new_entry         = '0;
    new_entry.busy    = 1'b1;
    new_entry.opcode  = bus.issue_opcode;
    new_entry.funct3  = bus.issue_funct3;
    new_entry.funct7  = bus.issue_funct7;
    new_entry.pend1   = bus.issue_rs1_pend && !byp1[DATA_W];
    new_entry.tag1    = bus.issue_rs1_tag;
    new_entry.val1    = bus.issue_rs1_pend ? byp1[DATA_W-1:0] : bus.issue_rs1_val;
    new_entry.pend2   = bus.issue_rs2_pend && !byp2[DATA_W];
    new_entry.tag2    = bus.issue_rs2_tag;
    new_entry.val2    = bus.issue_rs2_pend ? byp2[DATA_W-1:0] : bus.issue_rs2_val;
    new_entry.imm     = bus.issue_imm;
    new_entry.pc      = bus.issue_pc;
    new_entry.rob_pos = bus.issue_rob_pos;
  end

  // Next entry state: wakeup, dispatch release, then issue write.
  always_comb begin
    entry_d = entry_q;
    wk1     = '0;
    wk2     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wk1 = cdb_lookup(entry_q[i].tag1, bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val);
      wk2 = cdb_lookup(entry_q[i].tag2, bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val);
      if (entry_q[i].busy && entry_q[i].pend1 && wk1[DATA_W]) begin
        entry_d[i].pend1 = 1'b0;
        entry_d[i].val1  = wk1[DATA_W-1:0];
      end
      if (entry_q[i].busy && entry_q[i].pend2 && wk2[DATA_W]) begin
        entry_d[i].pend2 = 1'b0;
        entry_d[i].val2  = wk2[DATA_W-1:0];
      end
    end
    if (sel_valid)    entry_d[sel_idx].busy = 1'b0;
    if (issue_accept) entry_d[free_idx]     = new_entry;
  end

  assign free_count_d = free_count_q - CNT_W'(issue_accept) + CNT_W'(sel_valid);

  // State update: reset beats everything, rdy low freezes, rollback empties the station.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      free_count_q  <= CNT_W'(DEPTH);
      alu_en_q      <= 1'b0;
      alu_opcode_q  <= '0;
      alu_funct3_q  <= '0;
      alu_funct7_q  <= 1'b0;
      alu_val1_q    <= '0;
      alu_val2_q    <= '0;
      alu_imm_q     <= '0;
      alu_pc_q      <= '0;
      alu_rob_pos_q <= '0;
    end else if (bus.rdy) begin
      if (bus.rollback) begin
        for (int i = 0; i < DEPTH; i++) entry_q[i].busy <= 1'b0;
        free_count_q <= CNT_W'(DEPTH);
        alu_en_q     <= 1'b0;
      end else begin
        entry_q      <= entry_d;
        free_count_q <= free_count_d;
        alu_en_q     <= sel_valid;
        if (sel_valid) begin
          alu_opcode_q  <= entry_q[sel_idx].opcode;
          alu_funct3_q  <= entry_q[sel_idx].funct3;
          alu_funct7_q  <= entry_q[sel_idx].funct7;
          alu_val1_q    <= entry_q[sel_idx].val1;
          alu_val2_q    <= entry_q[sel_idx].val2;
          alu_imm_q     <= entry_q[sel_idx].imm;
          alu_pc_q      <= entry_q[sel_idx].pc;
          alu_rob_pos_q <= entry_q[sel_idx].rob_pos;
        end
      end
    end
  end

  // Two channels broadcasting the same ROB tag in one cycle is a producer bug.
  always_comb begin
    cdb_dup = 1'b0;
    for (int a = 0; a < NUM_CDB; a++) begin
      for (int b = a + 1; b < NUM_CDB; b++) begin
        if (bus.cdb_valid[a] && bus.cdb_valid[b] &&
            bus.cdb_rob_pos[a*ROB_POS_W +: ROB_POS_W] == bus.cdb_rob_pos[b*ROB_POS_W +: ROB_POS_W])
          cdb_dup = 1'b1;
      end
    end
  end

  // Protocol checks on cycles where the station actually updates.
  always_ff @(posedge clk) begin
    if (rst_n && bus.rdy && !bus.rollback) begin
      a_issue_when_full : assert (!(bus.issue && free_count_q == '0));
      a_cdb_dup_tag     : assert (!cdb_dup);
    end
  end

  assign bus.rs_full     = (free_count_q <= CNT_W'(bus.issue));
  assign bus.free_count  = free_count_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_funct3  = alu_funct3_q;
  assign bus.alu_funct7  = alu_funct7_q;
  assign bus.alu_val1    = alu_val1_q;
  assign bus.alu_val2    = alu_val2_q;
  assign bus.alu_imm     = alu_imm_q;
  assign bus.alu_pc      = alu_pc_q;
  assign bus.alu_rob_pos = alu_rob_pos_q;

endmodule

// File: tb/tb_rs_gen2.sv
// Directed bench for rs_gen2: dispatch latency, issue bypass, wakeup, age order
// across ROB wrap, full/free accounting, rollback and rdy stall.
module tb_rs_gen2;
  import rs_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rs_gen2_if #(.DEPTH(16), .NUM_CDB(2)) bus ();

  rs_gen2 #(.DEPTH(16), .NUM_CDB(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_issue(input int pos, input int p1, input int t1, input int v1,
                           input int p2, input int t2, input int v2);
    bus.issue          = 1'b1;
    bus.issue_rob_pos  = rob_pos_t'(pos);
    bus.issue_rs1_pend = p1[0];
    bus.issue_rs1_tag  = rob_pos_t'(t1);
    bus.issue_rs1_val  = DATA_W'(v1);
    bus.issue_rs2_pend = p2[0];
    bus.issue_rs2_tag  = rob_pos_t'(t2);
    bus.issue_rs2_val  = DATA_W'(v2);
  endtask

  task automatic cdb(input int ch, input int tag, input int val);
    bus.cdb_valid[ch]                             = 1'b1;
    bus.cdb_rob_pos[ch*ROB_POS_W +: ROB_POS_W]    = rob_pos_t'(tag);
    bus.cdb_val[ch*DATA_W +: DATA_W]              = DATA_W'(val);
  endtask

  task automatic cdb_clr();
    bus.cdb_valid   = '0;
    bus.cdb_rob_pos = '0;
    bus.cdb_val     = '0;
  endtask

  initial begin
    bus.rdy = 1'b1; bus.rollback = 1'b0; bus.rob_head = '0; bus.issue = 1'b0;
    bus.issue_rob_pos = '0; bus.issue_opcode = '0; bus.issue_funct3 = '0;
    bus.issue_funct7 = 1'b0; bus.issue_rs1_pend = 1'b0; bus.issue_rs2_pend = 1'b0;
    bus.issue_rs1_tag = '0; bus.issue_rs2_tag = '0; bus.issue_rs1_val = '0;
    bus.issue_rs2_val = '0; bus.issue_imm = '0; bus.issue_pc = '0;
    cdb_clr();

    // reset
    cyc(); cyc();
    chk("rst_alu_en",  64'(bus.alu_en),      64'h0);
    chk("rst_free",    64'(bus.free_count),  64'd16);
    chk("rst_full",    64'(bus.rs_full),     64'h0);
    chk("rst_val1",    64'(bus.alu_val1),    64'h0);
    chk("rst_rob_pos", 64'(bus.alu_rob_pos), 64'h0);
    rst_n = 1'b1;

    // basic dispatch
    set_issue(3, 0, 0, 5, 0, 0, 7);
    bus.issue_opcode = 7'h33; bus.issue_funct3 = 3'd5; bus.issue_pc = 32'h100; bus.issue_imm = 32'h10;
    #1 chk("basic_full_during_issue", 64'(bus.rs_full), 64'h0);
    cyc(); bus.issue = 1'b0;
    chk("basic_free_after_issue", 64'(bus.free_count), 64'd15);
    chk("basic_no_early_en",      64'(bus.alu_en),     64'h0);
    cyc();
    chk("basic_en",     64'(bus.alu_en),      64'h1);
    chk("basic_val1",   64'(bus.alu_val1),    64'd5);
    chk("basic_val2",   64'(bus.alu_val2),    64'd7);
    chk("basic_rob",    64'(bus.alu_rob_pos), 64'd3);
    chk("basic_pc",     64'(bus.alu_pc),      64'h100);
    chk("basic_imm",    64'(bus.alu_imm),     64'h10);
    chk("basic_opcode", 64'(bus.alu_opcode),  64'h33);
    chk("basic_funct3", 64'(bus.alu_funct3),  64'h5);
    chk("basic_free",   64'(bus.free_count),  64'd16);
    cyc();
    chk("basic_en_pulse", 64'(bus.alu_en), 64'h0);

    // issue-cycle bypass from channel 1
    set_issue(7, 1, 6, 32'h1111, 0, 0, 9);
    cdb(1, 6, 32'hDEAD);
    cyc(); bus.issue = 1'b0; cdb_clr();
    chk("byp_en_wait", 64'(bus.alu_en), 64'h0);
    cyc();
    chk("byp_en",   64'(bus.alu_en),      64'h1);
    chk("byp_val1", 64'(bus.alu_val1),    64'hDEAD);
    chk("byp_val2", 64'(bus.alu_val2),    64'd9);
    chk("byp_rob",  64'(bus.alu_rob_pos), 64'd7);

    // wakeup on channel 0 for a pending rs2
    set_issue(8, 0, 0, 32'h21, 1, 5, 0);
    cyc(); bus.issue = 1'b0;
    chk("wk_idle_en", 64'(bus.alu_en), 64'h0);
    cyc();
    chk("wk_still_pend", 64'(bus.alu_en),     64'h0);
    chk("wk_free",       64'(bus.free_count), 64'd15);
    cdb(0, 5, 32'h55);
    cyc(); cdb_clr();
    chk("wk_not_same_edge", 64'(bus.alu_en), 64'h0);
    cyc();
    chk("wk_en",   64'(bus.alu_en),      64'h1);
    chk("wk_val1", 64'(bus.alu_val1),    64'h21);
    chk("wk_val2", 64'(bus.alu_val2),    64'h55);
    chk("wk_rob",  64'(bus.alu_rob_pos), 64'd8);

    // age order across ROB wrap: head 14, positions 1, 15, 14
    bus.rob_head = 4'd14;
    set_issue(1,  1, 9, 0, 0, 0, 32'h1); cyc();
    set_issue(15, 1, 9, 0, 0, 0, 32'hF); cyc();
    set_issue(14, 1, 9, 0, 0, 0, 32'hE); cyc();
    bus.issue = 1'b0;
    chk("age_free_three", 64'(bus.free_count), 64'd13);
    cdb(0, 9, 32'h99);
    cyc(); cdb_clr();
    chk("age_en_wait", 64'(bus.alu_en), 64'h0);
    cyc();
    chk("age_first_en",   64'(bus.alu_en),      64'h1);
    chk("age_first_rob",  64'(bus.alu_rob_pos), 64'd14);
    chk("age_first_val1", 64'(bus.alu_val1),    64'h99);
    chk("age_first_val2", 64'(bus.alu_val2),    64'hE);
    cyc();
    chk("age_second_rob", 64'(bus.alu_rob_pos), 64'd15);
    chk("age_second_en",  64'(bus.alu_en),      64'h1);
    cyc();
    chk("age_third_rob",  64'(bus.alu_rob_pos), 64'd1);
    chk("age_third_en",   64'(bus.alu_en),      64'h1);
    cyc();
    chk("age_done_en",    64'(bus.alu_en),      64'h0);
    chk("age_done_free",  64'(bus.free_count),  64'd16);

    // fill all 16 entries with pending operands
    bus.rob_head = 4'd0;
    for (int i = 0; i < 16; i++) begin
      set_issue(i, 1, i, 0, 0, 0, i);
      #1;
      if (i == 14) chk("full_not_yet", 64'(bus.rs_full), 64'h0);
      if (i == 15) begin
        chk("full_on_16th",      64'(bus.rs_full),    64'h1);
        chk("full_free_on_16th", 64'(bus.free_count), 64'd1);
      end
      cyc();
    end
    bus.issue = 1'b0;
    #1;
    chk("full_free_zero", 64'(bus.free_count), 64'd0);
    chk("full_flag",      64'(bus.rs_full),    64'h1);
    cdb(1, 4, 32'h44);
    cyc(); cdb_clr();
    chk("full_wait_en",   64'(bus.alu_en),     64'h0);
    chk("full_wait_free", 64'(bus.free_count), 64'd0);
    cyc();
    chk("full_disp_en",   64'(bus.alu_en),      64'h1);
    chk("full_disp_rob",  64'(bus.alu_rob_pos), 64'd4);
    chk("full_disp_val1", 64'(bus.alu_val1),    64'h44);
    chk("full_disp_val2", 64'(bus.alu_val2),    64'd4);
    chk("full_free_one",  64'(bus.free_count),  64'd1);
    chk("full_released",  64'(bus.rs_full),     64'h0);

    // rollback with 15 busy entries, a concurrent ready issue and a broadcast
    bus.rollback = 1'b1;
    set_issue(2, 0, 0, 1, 0, 0, 2);
    cdb(0, 5, 32'h5);
    cyc(); bus.rollback = 1'b0; bus.issue = 1'b0; cdb_clr();
    chk("flush_free", 64'(bus.free_count), 64'd16);
    chk("flush_full", 64'(bus.rs_full),    64'h0);
    chk("flush_en",   64'(bus.alu_en),     64'h0);
    for (int k = 0; k < 8; k++) begin
      cdb(0, 2*k, 32'h70);
      cdb(1, 2*k + 1, 32'h71);
      cyc();
      chk("flush_no_dispatch", 64'(bus.alu_en), 64'h0);
    end
    cdb_clr();
    cyc();
    chk("flush_no_dispatch_tail", 64'(bus.alu_en),     64'h0);
    chk("flush_free_tail",        64'(bus.free_count), 64'd16);

    // rdy stall with alu_en high and a CDB pulse
    set_issue(4, 1, 12, 0, 0, 0, 32'h42); cyc();
    set_issue(3, 0, 0, 32'h31, 0, 0, 32'h32); cyc();
    bus.issue = 1'b0; cyc();
    chk("stall_pre_en",   64'(bus.alu_en),      64'h1);
    chk("stall_pre_rob",  64'(bus.alu_rob_pos), 64'd3);
    chk("stall_pre_free", 64'(bus.free_count),  64'd15);
    bus.rdy = 1'b0;
    cdb(0, 12, 32'hC0);
    set_issue(9, 0, 0, 9, 0, 0, 9);
    repeat (3) begin
      cyc();
      chk("stall_en_held",   64'(bus.alu_en),      64'h1);
      chk("stall_rob_held",  64'(bus.alu_rob_pos), 64'd3);
      chk("stall_val1_held", 64'(bus.alu_val1),    64'h31);
      chk("stall_free_held", 64'(bus.free_count),  64'd15);
    end
    bus.rdy = 1'b1; bus.issue = 1'b0; cdb_clr();
    cyc();
    chk("stall_cdb_not_captured", 64'(bus.alu_en),     64'h0);
    chk("stall_issue_ignored",    64'(bus.free_count), 64'd15);
    cyc();
    chk("stall_still_pend", 64'(bus.alu_en), 64'h0);
    cdb(0, 12, 32'hC1);
    cyc(); cdb_clr();
    chk("stall_wake_wait", 64'(bus.alu_en), 64'h0);
    cyc();
    chk("stall_wake_en",   64'(bus.alu_en),      64'h1);
    chk("stall_wake_rob",  64'(bus.alu_rob_pos), 64'd4);
    chk("stall_wake_val1", 64'(bus.alu_val1),    64'hC1);
    chk("stall_wake_free", 64'(bus.free_count),  64'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
